// File: rtl/led_drv.sv
// LED pin driver: buffers OFF/ON/BLINK/PWM commands through a one-deep
// valid/ready slot and applies them only on PWM period boundaries.
module led_drv #(
    parameter int unsigned div_ratio     = 10,
    parameter int unsigned pwm_bits      = 4,
    parameter int unsigned blink_periods = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [pwm_bits-1:0] cmd_level,
    output logic                led
);

    localparam int unsigned DIV_W = (div_ratio > 1) ? $clog2(div_ratio) : 1;
    localparam int unsigned BLK_W = (blink_periods > 1) ? $clog2(blink_periods) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(div_ratio - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(blink_periods - 1);
    localparam logic [pwm_bits-1:0] PWM_LAST = '1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    typedef struct packed {
        logic [1:0]          mode;
        logic [pwm_bits-1:0] level;
    } cmd_t;

    localparam cmd_t CMD_RESET = '{mode: MODE_OFF, level: '0};

    logic [DIV_W-1:0]    div_q,       div_d;
    logic                tick_q,      tick_d;
    logic [pwm_bits-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic                ready_q,     ready_d;
    cmd_t                slot_q,      slot_d;
    cmd_t                act_q,       act_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                phase_q,     phase_d;
    logic                led_q,       led_d;

    logic boundary;
    logic apply;
    logic accept;
    logic lit;

    // Prescaler and free-running PWM counter.
    always_comb begin
        div_d     = div_q;
        tick_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q;

        if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (tick_q) begin
            pwm_cnt_d = pwm_cnt_q + pwm_bits'(1);
        end
    end

    assign boundary = tick_q && (pwm_cnt_q == PWM_LAST);
    // The slot is full exactly when ready is low, so accept and apply never coincide.
    assign apply    = boundary && !ready_q;
    assign accept   = cmd_valid && ready_q;

    // Command slot, active command and blink phase.
    always_comb begin
        ready_d     = ready_q;
        slot_d      = slot_q;
        act_d       = act_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        if (apply) begin
            act_d       = slot_q;
            ready_d     = 1'b1;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (boundary) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        if (accept) begin
            slot_d.mode  = cmd_mode;
            slot_d.level = cmd_level;
            ready_d      = 1'b0;
        end
    end

    assign lit = (pwm_cnt_q < act_q.level);

    // Pin value from the current state, registered one cycle later.
    always_comb begin
        led_d = 1'b0;
        case (act_q.mode)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase_q && lit;
            MODE_PWM:   led_d = lit;
            default:    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            tick_q      <= 1'b0;
            pwm_cnt_q   <= '0;
            ready_q     <= 1'b1;
            slot_q      <= CMD_RESET;
            act_q       <= CMD_RESET;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            tick_q      <= tick_d;
            pwm_cnt_q   <= pwm_cnt_d;
            ready_q     <= ready_d;
            slot_q      <= slot_d;
            act_q       <= act_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign cmd_ready = ready_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_drv.sv
// Scoreboard bench for led_drv: stimulus queues the expected high-time of each
// 160-clk LED period; a monitor checks every period's pulse shape and count.
module tb_led_drv;

    localparam int PER = 160;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode  = 2'd0;
    logic [3:0] cmd_level = 4'd0;
    logic       led;

    led_drv #(
        .div_ratio    (10),
        .pwm_bits     (4),
        .blink_periods(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_level(cmd_level),
        .led      (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int win;
        int high;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    // Posedges since reset release; LED period w covers cyc 2+160w .. 161+160w.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic tally(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else    $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic push(input int w, input int h);
        exp_t e;
        e.win  = w;
        e.high = h;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] l, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_level = l;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready) begin
            @(posedge clk);
            #1 acc = cyc;
        end else begin
            tally(1'b0, "send_timeout", 0, 1);
        end
        cmd_valid = 1'b0;
    endtask

    // Monitor: one comparison per complete LED period.
    exp_t cur;
    bit   have    = 1'b0;
    int   highs   = 0;
    int   bad_pos = -1;
    int   mw, mp;

    always @(negedge clk) begin
        if (mon_en && rst && cyc >= 2) begin
            mw = (cyc - 2) / PER;
            mp = (cyc - 2) % PER;
            if (mp == 0) begin
                highs   = 0;
                bad_pos = -1;
                have    = (exp_q.size() > 0);
                if (have) cur = exp_q.pop_front();
            end
            if (led) highs++;
            if (have && bad_pos < 0 && (led !== (mp < cur.high))) bad_pos = mp;
            if (mp == PER - 1) begin
                if (!have)
                    tally(1'b0, $sformatf("period%0d_no_expectation", mw), highs, -1);
                else
                    tally(bad_pos < 0 && cur.win == mw,
                          $sformatf("period%0d_high_clk(first_bad_pos=%0d,exp_period=%0d)",
                                    mw, bad_pos, cur.win),
                          highs, cur.high);
            end
        end
    end

    initial begin
        int acc;
        int post_high;
        int post_nready;

        // Reset held low with a command offered.
        #2 rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        repeat (3) @(negedge clk);
        tally(led == 1'b0, "reset_led", int'(led), 0);
        tally(cmd_ready == 1'b1, "reset_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b0;
        push(0, 0);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // ON right after reset: waits for the first boundary at edge 161.
        send(2'd1, 4'd0, acc);
        tally(acc == 2, "on_accept_cycle", acc, 2);
        push(1, PER);
        wait_cyc(160);
        tally(cmd_ready == 1'b0, "ready_low_until_apply", int'(cmd_ready), 0);
        wait_cyc(161);
        tally(cmd_ready == 1'b1, "ready_high_after_apply", int'(cmd_ready), 1);

        // PWM duty patterns.
        wait_cyc(2 + PER * 1 + 50);
        send(2'd3, 4'd4, acc);
        push(2, 40);
        push(3, 40);
        wait_cyc(2 + PER * 3 + 50);
        send(2'd3, 4'd0, acc);
        push(4, 0);
        wait_cyc(2 + PER * 4 + 50);
        send(2'd3, 4'd15, acc);
        push(5, 150);

        // Back-to-back: the second command stalls until the first applies.
        wait_cyc(2 + PER * 5 + 50);
        send(2'd3, 4'd8, acc);
        push(6, 80);
        @(negedge clk);
        tally(cmd_ready == 1'b0, "ready_low_after_accept", int'(cmd_ready), 0);
        send(2'd0, 4'd0, acc);
        tally(acc == 962, "stalled_accept_cycle", acc, 962);
        push(7, 0);

        // BLINK at full level: two lit periods, two dark, repeating.
        wait_cyc(2 + PER * 7 + 50);
        send(2'd2, 4'd15, acc);
        push(8, 150);
        push(9, 150);
        push(10, 0);
        push(11, 0);
        push(12, 150);
        push(13, 150);

        // Re-send during the second lit period restarts the lit phase.
        wait_cyc(2 + PER * 13 + 50);
        send(2'd2, 4'd15, acc);
        push(14, 150);
        push(15, 150);
        push(16, 0);
        push(17, 0);

        // Async reset mid-BLINK with an ON command pending.
        wait_cyc(2 + PER * 18 + 20);
        tally(led == 1'b1, "blink_lit_before_reset", int'(led), 1);
        send(2'd1, 4'd0, acc);
        @(negedge clk);
        tally(cmd_ready == 1'b0, "slot_full_before_reset", int'(cmd_ready), 0);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        tally(led == 1'b0, "async_reset_led", int'(led), 0);
        tally(cmd_ready == 1'b1, "async_reset_ready", int'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        post_high   = 0;
        post_nready = 0;
        repeat (400) begin
            @(negedge clk);
            if (led)        post_high++;
            if (!cmd_ready) post_nready++;
        end
        tally(post_high == 0, "discarded_cmd_led_high_clk", post_high, 0);
        tally(post_nready == 0, "ready_low_clk_after_reset", post_nready, 0);
        tally(exp_q.size() == 0, "scoreboard_left_over", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
